// File: rtl/ibuf_multibank_queue.sv
// ID1->ID2 instruction buffer: up to LANES instructions in/out per cycle, stored
// interleaved over LANES circular banks, presented oldest-first from a registered output stage.
module ibuf_multibank_queue #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 106
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [LANES-1:0]                i_valid,
  input  logic [LANES*DATA_W-1:0]         i_data,
  input  logic                            flush,
  input  logic                            stall,
  output logic [LANES-1:0]                o_valid,
  output logic [LANES*DATA_W-1:0]         o_data,
  output logic                            o_full,
  output logic [$clog2(LANES*DEPTH+1)-1:0] o_count,
  output logic                            o_nonempty
);
  localparam int CAP = LANES * DEPTH;
  localparam int CW  = $clog2(CAP + 1);
  localparam int BW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW  = $clog2(DEPTH);

  logic [DATA_W-1:0]       mem_q [LANES][DEPTH];
  logic [PW-1:0]           head_q [LANES];
  logic [PW-1:0]           head_d [LANES];
  logic [PW-1:0]           tail_q [LANES];
  logic [PW-1:0]           tail_d [LANES];
  logic [BW-1:0]           wr_bank_q, wr_bank_d;
  logic [BW-1:0]           rd_bank_q, rd_bank_d;
  logic [CW-1:0]           count_q, count_d;
  logic [LANES-1:0]        o_valid_q, o_valid_d;
  logic [LANES*DATA_W-1:0] o_data_q, o_data_d;
  logic                    o_full_q, o_full_d;
  logic [LANES-1:0]        we;
  logic [DATA_W-1:0]       wdata [LANES];
  logic [CW:0]             count_nx;
  logic [BW-1:0]           wb, rb;
  int                      n_in, n_out;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    we        = '0;
    wb        = '0;
    rb        = '0;
    n_in      = 0;
    n_out     = 0;
    for (int b = 0; b < LANES; b++) wdata[b] = '0;

    // Compact valid lanes onto consecutive banks starting at wr_bank.
    if (!flush && !o_full_q) begin
      for (int k = 0; k < LANES; k++) begin
        if (i_valid[k]) begin
          wb = BW'((int'(wr_bank_q) + n_in) % LANES);
          we[wb]     = 1'b1;
          wdata[wb]  = i_data[k*DATA_W +: DATA_W];
          tail_d[wb] = tail_q[wb] + 1'b1;
          n_in       = n_in + 1;
        end
      end
      wr_bank_d = BW'((int'(wr_bank_q) + n_in) % LANES);
    end

    // Only entries counted before this edge are eligible; no write-to-read bypass.
    if (!stall) begin
      n_out     = (int'(count_q) < LANES) ? int'(count_q) : LANES;
      o_valid_d = '0;
      o_data_d  = '0;
      for (int j = 0; j < LANES; j++) begin
        if (j < n_out) begin
          rb = BW'((int'(rd_bank_q) + j) % LANES);
          o_valid_d[j]                  = 1'b1;
          o_data_d[j*DATA_W +: DATA_W]  = mem_q[rb][head_q[rb]];
          head_d[rb]                    = head_q[rb] + 1'b1;
        end
      end
      rd_bank_d = BW'((int'(rd_bank_q) + n_out) % LANES);
    end

    count_nx = {1'b0, count_q} + (CW+1)'(n_in) - (CW+1)'(n_out);
    count_d  = count_nx[CW-1:0];
    o_full_d = (count_nx > (CW+1)'(CAP - LANES));
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      for (int b = 0; b < LANES; b++) begin
        head_q[b] <= '0;
        tail_q[b] <= '0;
      end
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      count_q   <= '0;
      o_valid_q <= '0;
      o_data_q  <= '0;
      o_full_q  <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      count_q   <= count_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_full_q  <= o_full_d;
    end
  end

  // Storage is not reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (we[b]) mem_q[b][tail_q[b]] <= wdata[b];
    end
  end

  assert property (@(posedge clk) disable iff (!rstn || flush) count_nx <= (CW+1)'(CAP));

  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign o_full     = o_full_q;
  assign o_count    = count_q;
  assign o_nonempty = |o_valid_q;
endmodule

// File: tb/tb_ibuf_multibank_queue.sv
// Bench for ibuf_multibank_queue (LANES=2, DEPTH=4): directed scenarios plus random
// traffic, checked by a FIFO reference model feeding an output-group scoreboard.
module tb_ibuf_multibank_queue;
  localparam int LANES  = 2;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 106;
  localparam int CAP    = LANES * DEPTH;
  localparam int CW     = $clog2(CAP + 1);

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [LANES-1:0]        i_valid = '0;
  logic [LANES*DATA_W-1:0] i_data = '0;
  logic                    flush = 1'b0;
  logic                    stall = 1'b0;
  logic [LANES-1:0]        o_valid;
  logic [LANES*DATA_W-1:0] o_data;
  logic                    o_full;
  logic [CW-1:0]           o_count;
  logic                    o_nonempty;

  ibuf_multibank_queue #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_data(i_data), .flush(flush),
    .stall(stall), .o_valid(o_valid), .o_data(o_data), .o_full(o_full),
    .o_count(o_count), .o_nonempty(o_nonempty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0]        v;
    logic [LANES*DATA_W-1:0] d;
  } grp_t;

  grp_t              exp_q[$];
  grp_t              last;
  grp_t              g_m;
  bit                have_last = 0;
  logic [DATA_W-1:0] ref_q[$];
  bit                mfull = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  int unsigned       seq = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk();
    logic [127:0] t;
    seq++;
    t = {$urandom, $urandom, $urandom, seq};
    return t[DATA_W-1:0];
  endfunction

  // Reference: one program-ordered FIFO; each consuming edge takes the oldest
  // min(LANES, size) entries before this edge's arrivals join the FIFO.
  always @(posedge clk) begin
    if (!rstn || flush) begin
      ref_q.delete();
      mfull = 0;
      g_m.v = '0;
      g_m.d = '0;
      exp_q.push_back(g_m);
    end else begin
      if (!stall) begin
        g_m.v = '0;
        g_m.d = '0;
        for (int j = 0; j < LANES; j++) begin
          if (ref_q.size() > 0) begin
            g_m.v[j] = 1'b1;
            g_m.d[j*DATA_W +: DATA_W] = ref_q.pop_front();
          end
        end
        exp_q.push_back(g_m);
      end
      if (!mfull) begin
        for (int k = 0; k < LANES; k++)
          if (i_valid[k]) ref_q.push_back(i_data[k*DATA_W +: DATA_W]);
      end
      mfull = (ref_q.size() > CAP - LANES);
    end
  end

  // Monitor: a new expected group appears for each loading edge; otherwise the
  // previous group must still be held.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      last = exp_q.pop_front();
      have_last = 1;
    end
    if (have_last) begin
      chk("sb_valid", o_valid, last.v);
      chk("sb_data", o_data, last.d);
      chk("sb_nonempty", o_nonempty, |last.v);
      chk("sb_count", o_count, ref_q.size());
      chk("sb_full", o_full, mfull);
    end
  end

  task automatic step(input logic [LANES-1:0] v, input logic [LANES*DATA_W-1:0] d,
                      input logic s, input logic f);
    @(negedge clk);
    i_valid = v;
    i_data  = d;
    stall   = s;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] a, b, c, d, e, f, g, z;

  initial begin
    z = '0;
    repeat (2) step('0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
    repeat (3) step('0, '0, 1'b0, 1'b0);
    chk("idle_valid", o_valid, 0);
    chk("idle_full", o_full, 0);
    chk("idle_count", o_count, 0);
    chk("idle_data", o_data, 0);

    a = mk(); b = mk();
    step(2'b11, {b, a}, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("ab_valid", o_valid, 2'b11);
    chk("ab_data", o_data, {b, a});
    chk("ab_count", o_count, 0);

    for (int i = 0; i < 4; i++) begin
      step(2'b11, {mk(), mk()}, 1'b1, 1'b0);
      if (i == 2) chk("not_full_at6", o_full, 0);
    end
    chk("full_at8", o_full, 1);
    chk("count_at8", o_count, 8);
    step(2'b11, {mk(), mk()}, 1'b1, 1'b0);
    chk("drop_count", o_count, 8);
    chk("drop_full", o_full, 1);
    repeat (5) step('0, '0, 1'b0, 1'b0);
    chk("drained_count", o_count, 0);

    c = mk(); d = mk(); e = mk();
    step(2'b10, {c, z}, 1'b1, 1'b0);
    step(2'b01, {z, d}, 1'b1, 1'b0);
    step(2'b10, {e, z}, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("cd_valid", o_valid, 2'b11);
    chk("cd_data", o_data, {d, c});
    step('0, '0, 1'b0, 1'b0);
    chk("e_valid", o_valid, 2'b01);
    chk("e_data", o_data, {z, e});

    repeat (3) step(2'b11, {mk(), mk()}, 1'b1, 1'b0);
    chk("pre_flush_count", o_count, 6);
    step(2'b11, {mk(), mk()}, 1'b1, 1'b1);
    chk("flush_valid", o_valid, 0);
    chk("flush_count", o_count, 0);
    chk("flush_full", o_full, 0);
    f = mk(); g = mk();
    step(2'b11, {g, f}, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("fg_valid", o_valid, 2'b11);
    chk("fg_data", o_data, {g, f});

    for (int i = 0; i < 500; i++) begin
      step(LANES'($urandom_range(0, 3)), {mk(), mk()},
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 49) == 0));
    end
    repeat (6) step('0, '0, 1'b0, 1'b0);
    chk("final_count", o_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
